// File: rtl/piso_tx_32bit.sv
// piso_tx_32bit: valid/ready parallel-in serial-out transmitter with a one-word holding buffer.
// Define PISO_LSB_FIRST_EN to transmit LSB first instead of MSB first.
module piso_tx_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] pi,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             so,
  output logic             so_valid,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  state_t state;
  logic [WIDTH-1:0] sr, hold, sr_next;
  logic [CW-1:0] cnt;
  logic buf_full, accept, last;
  assign load_ready = !buf_full;
  assign accept = load_valid && load_ready;
  assign last = cnt == CW'(WIDTH - 1);
  assign so_valid = state == SHIFT;
  assign done = so_valid && last && shift_en;
`ifdef PISO_LSB_FIRST_EN
  assign so = sr[0];
  assign sr_next = {1'b0, sr[WIDTH-1:1]};
`else
  assign so = sr[WIDTH-1];
  assign sr_next = {sr[WIDTH-2:0], 1'b0};
`endif
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      state <= IDLE;
      sr <= '0;
      hold <= '0;
      buf_full <= 1'b0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        sr <= pi;
        cnt <= '0;
        state <= SHIFT;
      end
    end else begin
      // an accept on the last-bit edge goes straight into sr, bypassing the buffer
      if (accept && !done) begin
        hold <= pi;
        buf_full <= 1'b1;
      end
      if (shift_en) begin
        if (!last) begin
          sr <= sr_next;
          cnt <= cnt + CW'(1);
        end else if (buf_full) begin
          sr <= hold;
          buf_full <= 1'b0;
          cnt <= '0;
        end else if (accept) begin
          sr <= pi;
          cnt <= '0;
        end else begin
          sr <= sr_next;
          cnt <= '0;
          state <= IDLE;
        end
      end
    end
endmodule

// File: tb/tb_piso_tx_32bit.sv
// tb_piso_tx_32bit: scoreboard bench for piso_tx_32bit; expected bits are queued on accept and popped as shifted.
module tb_piso_tx_32bit;
  localparam int W = 32;
  logic clk = 1'b0;
  logic clear_n = 1'b0;
  logic [W-1:0] pi = '0;
  logic load_valid = 1'b0;
  logic load_ready;
  logic shift_en = 1'b1;
  logic so, so_valid, done;
  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit last_q[$];

  piso_tx_32bit #(.WIDTH(W)) dut (
    .clk(clk), .clear_n(clear_n), .pi(pi), .load_valid(load_valid), .load_ready(load_ready),
    .shift_en(shift_en), .so(so), .so_valid(so_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
`ifdef PISO_LSB_FIRST_EN
      exp_q.push_back(w[i]);
`else
      exp_q.push_back(w[W-1-i]);
`endif
      last_q.push_back(i == W - 1);
    end
  endtask

  task automatic monitor();
    logic exp_done;
    forever begin
      @(negedge clk);
      if (clear_n) begin
        exp_done = so_valid && shift_en && last_q.size() > 0 && last_q[0];
        checks++;
        if (done !== exp_done) begin
          errors++;
          $display("FAIL done t=%0t got %b expected %b", $time, done, exp_done);
        end
        if (so_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL residual so_valid t=%0t with no word outstanding", $time);
          end else begin
            if (so !== exp_q[0]) begin
              errors++;
              $display("FAIL so t=%0t got %b expected %b", $time, so, exp_q[0]);
            end
            if (shift_en) begin
              void'(exp_q.pop_front());
              void'(last_q.pop_front());
            end
          end
        end
        if (load_valid && load_ready) push_word(pi);
      end
    end
  endtask

  task automatic accept_word(input logic [W-1:0] w);
    pi = w;
    load_valid = 1'b1;
    tick(1);
    load_valid = 1'b0;
    pi = $urandom;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0 || so_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s drain: %0d bits left, so_valid %b, expected 0 and 0", name, exp_q.size(), so_valid);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({so, so_valid, done, load_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset outputs got so/v/done/rdy %b expected 0001", {so, so_valid, done, load_ready});
    end
    @(posedge clk);
    #2 clear_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    int nv = 0;
    int dpos = 0;
    accept_word(32'h8000_0001);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (so_valid) nv++;
      if (done) dpos = c;
      @(posedge clk);
      #1;
    end
    checks++;
    if (nv != 32 || dpos != 32) begin
      errors++;
      $display("FAIL single frame: valid cycles %0d done cycle %0d, expected 32 and 32", nv, dpos);
    end
    check_drained("single");
  endtask

  task automatic test_back_to_back();
    int d1 = 0;
    int d2 = 0;
    accept_word(32'hFFFF_0000);
    tick(1);
    accept_word(32'h0000_FFFF);
    for (int c = 3; c <= 72; c++) begin
      @(negedge clk);
      checks++;
      if (so_valid !== (c <= 64) || load_ready !== (c > 32)) begin
        errors++;
        $display("FAIL b2b cycle %0d: so_valid %b load_ready %b, expected %b %b", c, so_valid, load_ready, c <= 64, c > 32);
      end
      if (done) begin
        if (d1 == 0) d1 = c;
        else d2 = c;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (d1 != 32 || d2 != 64) begin
      errors++;
      $display("FAIL b2b done pulses at %0d and %0d, expected 32 and 64", d1, d2);
    end
    check_drained("b2b");
  endtask

  task automatic test_stall();
    int nv = 0;
    int dpos = 0;
    accept_word(32'hA5A5_A5A5);
    for (int c = 1; c <= 70; c++) begin
      shift_en = (c % 2 == 0);
      @(negedge clk);
      if (so_valid) nv++;
      if (done) dpos = c;
      @(posedge clk);
      #1;
    end
    shift_en = 1'b1;
    checks++;
    if (nv != 64 || dpos != 64) begin
      errors++;
      $display("FAIL stall: valid cycles %0d done cycle %0d, expected 64 and 64", nv, dpos);
    end
    check_drained("stall");
  endtask

  task automatic test_mid_reset();
    int nv = 0;
    accept_word(32'h1234_5678);
    accept_word(32'h9ABC_DEF0);
    tick(9);
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset buffer not full: load_ready %b expected 0", load_ready);
    end
    #2 clear_n = 1'b0;
    #1;
    checks++;
    if ({so, so_valid, done, load_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL midreset outputs got so/v/done/rdy %b expected 0001", {so, so_valid, done, load_ready});
    end
    exp_q.delete();
    last_q.delete();
    @(posedge clk);
    #2 clear_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (so_valid || so || !load_ready) nv++;
    end
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL midreset residual activity in %0d cycles, expected 0", nv);
    end
    tick(1);
  endtask

  task automatic test_last_edge();
    int nv = 0;
    accept_word(32'hC000_0003);
    tick(31);
    pi = 32'h1;
    load_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL last-edge setup: done %b load_ready %b, expected 1 1", done, load_ready);
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      checks++;
      if (so_valid !== (c <= 32)) begin
        errors++;
        $display("FAIL last-edge cycle %0d so_valid %b expected %b", c, so_valid, c <= 32);
      end
      @(posedge clk);
      #1;
    end
    check_drained("last_edge");
  endtask

  task automatic test_words();
    accept_word(32'h8000_0001);
    accept_word(32'h0000_0003);
    tick(70);
    check_drained("words");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_last_edge();
    test_words();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
